// File: rtl/cpu7_mem_arb_pkg.sv
`default_nettype none
// =============================================================================
// Module      : cpu7_mem_arb_pkg
// Description : Shared types for the cpu7 two-to-one memory arbiter.
// Revision    : 1.0 - initial release
// =============================================================================
package cpu7_mem_arb_pkg;

   // Width of the address/data fields carried in the issue slot.
   localparam int c_grlen = 32;

   localparam logic SRC_INST = 1'b0;
   localparam logic SRC_DATA = 1'b1;

   typedef struct packed {
      logic               valid;
      logic               src;
      logic               wr;
      logic [3:0]         wstrb;
      logic [c_grlen-1:0] addr;
      logic [c_grlen-1:0] wdata;
      logic               kill;
   } slot_t;

   typedef struct packed {
      logic src;
      logic kill;
   } tag_t;

endpackage
`default_nettype wire

// File: rtl/cpu7_tag_fifo.sv
`default_nettype none
// =============================================================================
// Module      : cpu7_tag_fifo
// Description : In-order tag FIFO with a broadcast kill of all inst entries.
// Revision    : 1.0 - initial release
// =============================================================================
module cpu7_tag_fifo
   import cpu7_mem_arb_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  tag_t                     push_tag,
   input  logic                     pop,
   input  logic                     kill_all_inst,
   output tag_t                     head,
   output logic [$clog2(DEPTH):0]   occ,
   output logic                     empty
);

   localparam int c_aw = $clog2(DEPTH);
   localparam logic [c_aw-1:0] c_ptr_one = c_aw'(1);
   localparam logic [c_aw:0]   c_occ_one = (c_aw+1)'(1);

   tag_t            r_mem [DEPTH];
   logic [c_aw-1:0] r_wr_ptr;
   logic [c_aw-1:0] r_rd_ptr;
   logic [c_aw:0]   r_occ;

   assign head  = r_mem[r_rd_ptr];
   assign occ   = r_occ;
   assign empty = (r_occ == '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_occ    <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (kill_all_inst && r_mem[i].src == SRC_INST) begin
               r_mem[i].kill <= 1'b1;
            end
         end
         // An inst tag entering during a cancel is killed as it lands.
         if (push) begin
            r_mem[r_wr_ptr].src  <= push_tag.src;
            r_mem[r_wr_ptr].kill <= push_tag.kill |
                                    (kill_all_inst && push_tag.src == SRC_INST);
            r_wr_ptr             <= r_wr_ptr + c_ptr_one;
         end
         if (pop) begin
            r_rd_ptr <= r_rd_ptr + c_ptr_one;
         end
         case ({push, pop})
            2'b10:   r_occ <= r_occ + c_occ_one;
            2'b01:   r_occ <= r_occ - c_occ_one;
            default: r_occ <= r_occ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/cpu7_mem_arb.sv
`default_nettype none
// =============================================================================
// Module      : cpu7_mem_arb
// Description : Round-robin IFU/EXU arbiter with one issue slot and in-order
//               response routing to a single downstream memory port.
// Revision    : 1.0 - initial release
// =============================================================================
module cpu7_mem_arb
   import cpu7_mem_arb_pkg::*;
#(
   parameter int GRLEN   = 32,
   parameter int MAX_OUT = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inst_req,
   input  logic [31:0]      inst_addr,
   output logic             inst_addr_ok,
   input  logic             inst_cancel,
   output logic [GRLEN-1:0] inst_rdata,
   output logic             inst_valid,
   input  logic             data_req,
   input  logic             data_wr,
   input  logic [3:0]       data_wstrb,
   input  logic [GRLEN-1:0] data_addr,
   input  logic [GRLEN-1:0] data_wdata,
   output logic             data_addr_ok,
   output logic [GRLEN-1:0] data_rdata,
   output logic             data_data_ok,
   output logic             mem_req,
   output logic             mem_wr,
   output logic [3:0]       mem_wstrb,
   output logic [GRLEN-1:0] mem_addr,
   output logic [GRLEN-1:0] mem_wdata,
   input  logic             mem_addr_ok,
   input  logic [GRLEN-1:0] mem_rdata,
   input  logic             mem_data_ok,
   output logic             arb_err
);

   localparam int c_aw = $clog2(MAX_OUT);
   localparam logic [c_aw+1:0] c_max_out = (c_aw+2)'(MAX_OUT);

   slot_t           r_slot;
   slot_t           w_slot_nxt;
   logic            r_last_grant;
   logic            r_arb_err;
   tag_t            w_head;
   logic [c_aw:0]   w_occ;
   logic            w_empty;
   logic            w_issue;
   logic            w_pop;
   logic            w_can_take;
   logic            w_grant_data;
   logic            w_take;
   logic [c_aw+1:0] w_credits;

   // Credits cover everything accepted and unanswered, slot included, so a
   // capture needs FIFO + slot to leave room for one more.
   assign w_issue      = r_slot.valid && mem_addr_ok;
   assign w_credits    = {1'b0, w_occ} + {{(c_aw+1){1'b0}}, r_slot.valid};
   assign w_can_take   = (!r_slot.valid || mem_addr_ok) && (w_credits < c_max_out);
   assign w_grant_data = data_req && (!inst_req || r_last_grant == SRC_INST);
   assign w_take       = w_can_take && (inst_req || data_req);

   assign inst_addr_ok = w_can_take && inst_req && !w_grant_data;
   assign data_addr_ok = w_can_take && w_grant_data;

   always_comb begin
      w_slot_nxt = r_slot;
      if (w_take) begin
         w_slot_nxt.valid = 1'b1;
         if (w_grant_data) begin
            w_slot_nxt.src   = SRC_DATA;
            w_slot_nxt.wr    = data_wr;
            w_slot_nxt.wstrb = data_wstrb;
            w_slot_nxt.addr  = data_addr;
            w_slot_nxt.wdata = data_wdata;
            w_slot_nxt.kill  = 1'b0;
         end else begin
            w_slot_nxt.src   = SRC_INST;
            w_slot_nxt.wr    = 1'b0;
            w_slot_nxt.wstrb = 4'b0000;
            w_slot_nxt.addr  = inst_addr;
            w_slot_nxt.wdata = '0;
            w_slot_nxt.kill  = inst_cancel;
         end
      end else begin
         if (w_issue) begin
            w_slot_nxt.valid = 1'b0;
         end
         // A presented fetch is never withdrawn; it just issues as killed.
         if (inst_cancel && r_slot.src == SRC_INST) begin
            w_slot_nxt.kill = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_slot       <= '0;
         r_last_grant <= SRC_INST;
         r_arb_err    <= 1'b0;
      end else begin
         r_slot <= w_slot_nxt;
         if (w_take) begin
            r_last_grant <= w_grant_data ? SRC_DATA : SRC_INST;
         end
         if (mem_data_ok && w_empty) begin
            r_arb_err <= 1'b1;
         end
      end
   end

   assign w_pop = mem_data_ok && !w_empty;

   cpu7_tag_fifo #(
      .DEPTH         (MAX_OUT)
   ) u_tag_fifo (
      .clk           (clk),
      .reset         (reset),
      .push          (w_issue),
      .push_tag      ('{src: r_slot.src, kill: r_slot.kill}),
      .pop           (w_pop),
      .kill_all_inst (inst_cancel),
      .head          (w_head),
      .occ           (w_occ),
      .empty         (w_empty)
   );

   assign mem_req   = r_slot.valid;
   assign mem_wr    = r_slot.wr;
   assign mem_wstrb = r_slot.wstrb;
   assign mem_addr  = r_slot.addr;
   assign mem_wdata = r_slot.wdata;

   // A cancel in the same cycle as an inst pop also suppresses that response.
   assign inst_valid   = w_pop && w_head.src == SRC_INST && !w_head.kill && !inst_cancel;
   assign data_data_ok = w_pop && w_head.src == SRC_DATA;
   assign inst_rdata   = mem_rdata;
   assign data_rdata   = mem_rdata;
   assign arb_err      = r_arb_err;

endmodule
`default_nettype wire
